// File: rtl/flit_link_serializer.sv
// Purpose: buffer wide NoC flits in a small FIFO and serialize each one as LANE_W beats on a narrow valid/ready link with SOF/EOF.
// Latency: a flit written into an idle, empty block shows as the SOF beat two cycles later; flits follow back-to-back with no bubble.
// Backpressure: link_rdy low holds the current beat stable; the flit input cannot be stalled, so a full FIFO drops the flit and counts it.
module flit_link_serializer #(
    parameter int FLIT_W     = 128,
    parameter int LANE_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_W-1:0]     flit_in,
    input  logic                  flit_in_vld,
    output logic [LANE_W-1:0]     link_data,
    output logic                  link_vld,
    output logic                  link_sof,
    output logic                  link_eof,
    input  logic                  link_rdy,
    output logic                  fifo_full,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int BEATS  = FLIT_W / LANE_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic [FLIT_W-1:0] shreg;
    logic [BEAT_W-1:0] beat;
    state_t            state;

    logic              fifo_has;
    logic              is_full;
    logic              push;
    logic              pop;
    logic              drop;
    logic              last_beat;
    logic [FLIT_W-1:0] head;

    // Push/pop/drop decisions all use the count held at the start of the cycle,
    // so a pop in the same cycle never frees room for an incoming flit.
    always_comb begin
        fifo_has  = (count != '0);
        is_full   = (count == CNT_W'(FIFO_DEPTH));
        push      = flit_in_vld && !is_full;
        drop      = flit_in_vld && is_full;
        last_beat = (beat == BEAT_W'(BEATS - 1));
        pop       = fifo_has && ((state == IDLE) ||
                                 (state == SEND && link_rdy && last_beat));
        head      = mem[rd_ptr];
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Flit storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    // FIFO pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            fifo_full <= (count_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

    // Saturating count of flits lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    // Serializer FSM: loads a flit, shifts it out one lane per accepted beat,
    // and chains straight into the next flit when one is waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            shreg    <= '0;
            link_vld <= 1'b0;
            link_sof <= 1'b0;
            link_eof <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_has) begin
                        shreg    <= head;
                        beat     <= '0;
                        state    <= SEND;
                        link_vld <= 1'b1;
                        link_sof <= 1'b1;
                        link_eof <= 1'b0;
                    end
                end
                SEND: begin
                    if (link_rdy) begin
                        if (!last_beat) begin
                            shreg    <= shreg >> LANE_W;
                            beat     <= beat + BEAT_W'(1);
                            link_sof <= 1'b0;
                            link_eof <= (beat == BEAT_W'(BEATS - 2));
                        end else if (fifo_has) begin
                            shreg    <= head;
                            beat     <= '0;
                            link_sof <= 1'b1;
                            link_eof <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            beat     <= '0;
                            link_vld <= 1'b0;
                            link_sof <= 1'b0;
                            link_eof <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    link_vld <= 1'b0;
                    link_sof <= 1'b0;
                    link_eof <= 1'b0;
                end
            endcase
        end
    end

    assign link_data = shreg[LANE_W-1:0];

endmodule
